// File: rtl/load_register_if.sv
// Bus bundle for load_register: capture data, controls and the registered outputs.
// The parity signal exists only when LOAD_REGISTER_PARITY_EN is defined.
interface load_register_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic             clr;
  logic [WIDTH-1:0] out;
  logic             changed;
`ifdef LOAD_REGISTER_PARITY_EN
  logic             parity;
`endif

  // The producer side drives data and controls, and observes the stored value.
  modport master (
    output in,
    output load,
    output clr,
    input  out,
    input  changed
`ifdef LOAD_REGISTER_PARITY_EN
    , input parity
`endif
  );

  // The register side.
  modport slave (
    input  in,
    input  load,
    input  clr,
    output out,
    output changed
`ifdef LOAD_REGISTER_PARITY_EN
    , output parity
`endif
  );
endinterface

// File: rtl/load_register.sv
// Parallel-load datapath register with synchronous clear and a one-cycle "changed" strobe.
// Optional registered even parity of the stored value, enabled by LOAD_REGISTER_PARITY_EN.
module load_register #(
  parameter int unsigned          WIDTH       = 16,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  load_register_if.slave  bus
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             changed_q, changed_d;
`ifdef LOAD_REGISTER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Next-state: clr outranks load; with neither, the register holds, so an
  // undefined `in` cannot leak into the stored value unless load is high.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    out_d = out_q;
    if (bus.clr) begin
      out_d = RESET_VALUE;
    end else if (bus.load) begin
      out_d = bus.in;
    end
    changed_d = (out_d != out_q);
`ifdef LOAD_REGISTER_PARITY_EN
    parity_d  = ^out_d;
`endif
  end

  // Reset is sampled on the clock edge and overrides clr/load on that edge.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    if (!rst_n) begin
      out_q     <= RESET_VALUE;
      changed_q <= 1'b0;
`ifdef LOAD_REGISTER_PARITY_EN
      parity_q  <= ^RESET_VALUE;
`endif
    end else begin
      out_q     <= out_d;
      changed_q <= changed_d;
`ifdef LOAD_REGISTER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign bus.out     = out_q;
  assign bus.changed = changed_q;
`ifdef LOAD_REGISTER_PARITY_EN
  assign bus.parity  = parity_q;
`endif

endmodule

// File: tb/tb_load_register.sv
// Directed testbench for load_register (16-bit, RESET_VALUE = 0).
// Parity checks are included when LOAD_REGISTER_PARITY_EN is defined.
module tb_load_register;
  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  load_register_if #(.WIDTH(WIDTH)) bus ();

  load_register #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs and outputs are then stable 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.load = 1'b1;
    bus.clr  = 1'b0;
    bus.in   = 16'hFFFF;
    step();
    step();
    checks++;
    if (bus.out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_out: got %h expected %h", bus.out, 16'h0000);
    end
    checks++;
    if (bus.changed !== 1'b0) begin
      errors++;
      $display("FAIL reset_changed: got %b expected %b", bus.changed, 1'b0);
    end
`ifdef LOAD_REGISTER_PARITY_EN
    checks++;
    if (bus.parity !== 1'b0) begin
      errors++;
      $display("FAIL reset_parity: got %b expected %b", bus.parity, 1'b0);
    end
`endif
    rst_n    = 1'b1;
    bus.load = 1'b0;
  endtask

  task automatic test_load_hold();
    bus.in   = 16'hAAAA;
    bus.load = 1'b1;
    #1;
    checks++;
    if (bus.out !== 16'h0000) begin
      errors++;
      $display("FAIL no_bypass: got %h expected %h", bus.out, 16'h0000);
    end
    step();
    checks++;
    if (bus.out !== 16'hAAAA) begin
      errors++;
      $display("FAIL load_out: got %h expected %h", bus.out, 16'hAAAA);
    end
    checks++;
    if (bus.changed !== 1'b1) begin
      errors++;
      $display("FAIL load_changed: got %b expected %b", bus.changed, 1'b1);
    end
    bus.in   = 16'h5555;
    bus.load = 1'b0;
    step();
    checks++;
    if (bus.out !== 16'hAAAA) begin
      errors++;
      $display("FAIL hold_out: got %h expected %h", bus.out, 16'hAAAA);
    end
    checks++;
    if (bus.changed !== 1'b0) begin
      errors++;
      $display("FAIL hold_changed: got %b expected %b", bus.changed, 1'b0);
    end
  endtask

  task automatic test_reload_same();
    bus.in   = 16'h1234;
    bus.load = 1'b1;
    step();
    checks++;
    if (bus.out !== 16'h1234 || bus.changed !== 1'b1) begin
      errors++;
      $display("FAIL first_load_1234: got out=%h changed=%b expected out=1234 changed=1",
               bus.out, bus.changed);
    end
    step();
    checks++;
    if (bus.out !== 16'h1234) begin
      errors++;
      $display("FAIL reload_out: got %h expected %h", bus.out, 16'h1234);
    end
    checks++;
    if (bus.changed !== 1'b0) begin
      errors++;
      $display("FAIL reload_changed: got %b expected %b", bus.changed, 1'b0);
    end
    bus.load = 1'b0;
  endtask

  task automatic test_x_in_hold();
    bus.in   = 'x;
    bus.load = 1'b0;
    step();
    step();
    checks++;
    if (bus.out !== 16'h1234 || bus.changed !== 1'b0) begin
      errors++;
      $display("FAIL x_in_hold: got out=%h changed=%b expected out=1234 changed=0",
               bus.out, bus.changed);
    end
  endtask

  task automatic test_clr_priority();
    bus.in   = 16'hBEEF;
    bus.load = 1'b1;
    step();
    checks++;
    if (bus.out !== 16'hBEEF) begin
      errors++;
      $display("FAIL load_beef: got %h expected %h", bus.out, 16'hBEEF);
    end
    bus.clr = 1'b1;
    bus.in  = 16'h0F0F;
    step();
    checks++;
    if (bus.out !== 16'h0000) begin
      errors++;
      $display("FAIL clr_priority_out: got %h expected %h", bus.out, 16'h0000);
    end
    checks++;
    if (bus.changed !== 1'b1) begin
      errors++;
      $display("FAIL clr_priority_changed: got %b expected %b", bus.changed, 1'b1);
    end
    bus.load = 1'b0;
    step();
    checks++;
    if (bus.out !== 16'h0000 || bus.changed !== 1'b0) begin
      errors++;
      $display("FAIL clr_at_reset_value: got out=%h changed=%b expected out=0000 changed=0",
               bus.out, bus.changed);
    end
    bus.clr = 1'b0;
  endtask

  task automatic test_reset_vs_load();
    bus.in   = 16'h00FF;
    bus.load = 1'b1;
    step();
    checks++;
    if (bus.out !== 16'h00FF || bus.changed !== 1'b1) begin
      errors++;
      $display("FAIL load_00ff: got out=%h changed=%b expected out=00ff changed=1",
               bus.out, bus.changed);
    end
    rst_n  = 1'b0;
    bus.in = 16'h1111;
    step();
    checks++;
    if (bus.out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_vs_load_out: got %h expected %h", bus.out, 16'h0000);
    end
    checks++;
    if (bus.changed !== 1'b0) begin
      errors++;
      $display("FAIL reset_vs_load_changed: got %b expected %b", bus.changed, 1'b0);
    end
`ifdef LOAD_REGISTER_PARITY_EN
    checks++;
    if (bus.parity !== 1'b0) begin
      errors++;
      $display("FAIL reset_vs_load_parity: got %b expected %b", bus.parity, 1'b0);
    end
`endif
    rst_n    = 1'b1;
    bus.load = 1'b0;
  endtask

`ifdef LOAD_REGISTER_PARITY_EN
  task automatic test_parity();
    logic [15:0] vec_in  [3] = '{16'h0001, 16'h0003, 16'h8000};
    logic        vec_par [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      bus.in   = vec_in[i];
      bus.load = 1'b1;
      step();
      checks++;
      if (bus.out !== vec_in[i] || bus.parity !== vec_par[i]) begin
        errors++;
        $display("FAIL parity_%0d: got out=%h parity=%b expected out=%h parity=%b",
                 i, bus.out, bus.parity, vec_in[i], vec_par[i]);
      end
    end
    bus.load = 1'b0;
  endtask
`endif

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.in   = '0;
    bus.load = 1'b0;
    bus.clr  = 1'b0;
    #2;
    test_reset();
    test_load_hold();
    test_reload_same();
    test_x_in_hold();
    test_clr_priority();
    test_reset_vs_load();
`ifdef LOAD_REGISTER_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
